dct_vec_checker: RTL and testbench
==================================

# dct_vec_checker

Parametrised, synthesizable stream checker for the 2D-DCT datapath. It replaces hand-written per-stage compare loops (1D, 2D, final) with one block that can be instantiated on any stage output. It compares a valid-qualified DUT vector stream lane-by-lane against an expected-vector SRAM, after a programmable start skew. It accumulates error statistics and captures the first mismatch.

## Interface
Parameters:
- BW, 11, bits per lane (12 for 2D/final stages)
- LANES, 8, lanes per vector
- DEPTH, 32768, max vectors per run
- AW, $clog2(DEPTH), expected-memory address width
- SKW, 16, skew counter width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches cfg_skew/cfg_count, begins run
- abort  in  1  returns to IDLE; counters hold, done not raised
- cfg_skew  in  SKW  clk cycles to ignore after start before first compare
- cfg_count  in  AW+1  vectors to compare (1..DEPTH; 0 → immediate done)
- dut_valid  in  1  dut_data valid this cycle
- dut_data  in  LANES*BW  DUT vector, lane 0 in LSBs
- exp_addr  out  AW  expected-memory read address
- exp_rd  out  1  read enable
- exp_data  in  LANES*BW  expected vector, valid 1 cycle after exp_rd
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- pass  out  1  level; 1 when last run finished with err_count==0
- err_count  out  AW+1  mismatching vectors, saturating
- lane_err  out  LANES  sticky OR of per-lane mismatches
- first_err_valid  out  1  first mismatch captured
- first_err_addr  out  AW  vector index of first mismatch

## Operation
- FSM: IDLE → SKEW → RUN → DRAIN → IDLE.
- IDLE: start → clear err_count, lane_err, first_err_*, pass; load skew counter. Go to SKEW (cfg_skew>0), RUN (cfg_skew==0, cfg_count>0) or DRAIN (cfg_count==0).
- SKEW: count down every cycle regardless of dut_valid; at 0 → RUN.
- RUN: each cycle with dut_valid: exp_rd=1, exp_addr=idx, dut_data registered into align stage, idx++. When idx reaches cfg_count-1 with dut_valid → DRAIN. dut_valid low stalls (no read, no compare).
- Compare stage (one cycle after exp_rd): per-lane inequality mask m. If m≠0: err_count++ (saturate at all-ones), lane_err|=m, and if !first_err_valid, capture the index. 
- DRAIN: one cycle for final compare; then done=1, pass=(err_count==0 incl. final compare), → IDLE.
- start while busy is ignored. abort takes priority over start and all transitions; it drops any in-flight compare.
- Exactly cfg_count compares per completed run.

## Timing
- Reset values: exp_addr=0, exp_rd=0, busy=0, done=0, pass=0, err_count=0, lane_err=0, first_err_valid=0, first_err_addr=0; FSM IDLE, idx=0.
- busy rises the cycle after start, falls with done.
- First exp_rd no earlier than start+1+cfg_skew cycles.
- Compare latency: 1 cycle after accepted dut beat; stats update the cycle after that.
- done pulses 2 cycles after the last accepted beat.
- Back-to-back: start accepted the cycle after done.
- Reset mid-run: all outputs to reset values immediately; no done.

## Structure
- Package dct_chk_pkg: state enum (IDLE, SKEW, RUN, DRAIN), default BW/LANES/DEPTH constants.
- Sub-module dct_lane_cmp (LANES×BW compare → LANES mask, registered), instantiated once.
- The expected memory is external (existing SRAM wrapper, 1-cycle read).

## Test plan
- cfg_skew=0, cfg_count=16, dut identical to memory, continuous valid → done at beat16+2, pass=1, err_count=0.
- cfg_count=16, lane 3 of vector 5 corrupted and lanes 0,7 of vector 9 corrupted → err_count=2, lane_err=8'h89, first_err_addr=5, pass=0.
- cfg_skew=9, valid toggling 1/0 → first exp_rd at start+10, 16 compares only, pass=1.
- cfg_count=0 → done 2 cycles after start, pass=1, no exp_rd.
- abort at beat 7 → busy low next cycle, no done. Then start again → stats cleared, run completes normally.
- reset asserted at beat 4, released → all outputs zero, FSM IDLE. A subsequent run passes.

Source files
------------

// File: rtl/dct_chk_pkg.sv
`default_nettype none
// dct_chk_pkg -- shared FSM encoding and default geometry for dct_vec_checker.
// Rev 1.0
package dct_chk_pkg;

  localparam int DEF_BW    = 11;
  localparam int DEF_LANES = 8;
  localparam int DEF_DEPTH = 32768;
  localparam int DEF_SKW   = 16;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SKEW  = 2'd1;
  localparam state_t S_RUN   = 2'd2;
  localparam state_t S_DRAIN = 2'd3;

endpackage
`default_nettype wire

// File: rtl/dct_lane_cmp.sv
`default_nettype none
// dct_lane_cmp -- registered lane-by-lane inequality mask of two LANES x BW vectors.
// Rev 1.0
module dct_lane_cmp
  import dct_chk_pkg::*;
#(
  parameter int BW    = DEF_BW,
  parameter int LANES = DEF_LANES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [LANES*BW-1:0]   act_vec,
  input  logic [LANES*BW-1:0]   exp_vec,
  output logic                  out_valid,
  output logic [LANES-1:0]      mask
);

  logic [LANES-1:0] neq;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign neq[l] = act_vec[l*BW +: BW] != exp_vec[l*BW +: BW];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      mask      <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
      mask      <= '0;
    end else begin
      out_valid <= in_valid;
      mask      <= in_valid ? neq : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dct_vec_checker.sv
`default_nettype none
// dct_vec_checker -- compares a valid-qualified vector stream against an expected SRAM.
// Rev 1.0
module dct_vec_checker
  import dct_chk_pkg::*;
#(
  parameter int BW    = DEF_BW,
  parameter int LANES = DEF_LANES,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH),
  parameter int SKW   = DEF_SKW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SKW-1:0]        cfg_skew,
  input  logic [AW:0]           cfg_count,
  input  logic                  dut_valid,
  input  logic [LANES*BW-1:0]   dut_data,
  output logic [AW-1:0]         exp_addr,
  output logic                  exp_rd,
  input  logic [LANES*BW-1:0]   exp_data,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [AW:0]           err_count,
  output logic [LANES-1:0]      lane_err,
  output logic                  first_err_valid,
  output logic [AW-1:0]         first_err_addr
);

  state_t                state;
  logic [SKW-1:0]        skew_cnt;
  logic [AW:0]           count;
  logic [AW-1:0]         idx;
  logic                  done_r;
  logic                  pass_r;

  logic                  beat_valid;
  logic [AW-1:0]         beat_idx;
  logic [LANES*BW-1:0]   dut_align;
  logic [AW-1:0]         cmp_idx;
  logic                  cmp_valid;
  logic [LANES-1:0]      mask;

  logic                  do_start;
  logic                  beat;
  logic                  last_beat;
  logic                  hit;
  logic                  clean;

  // A start in the done cycle would collide with the final stats update.
  assign do_start  = start && (state == S_IDLE) && !done_r && !abort;
  assign beat      = (state == S_RUN) && dut_valid && !abort;
  assign last_beat = ({1'b0, idx} == (count - 1'b1));
  assign hit       = cmp_valid && !abort && (mask != '0);
  assign clean     = (err_count == '0) && !hit;

  assign exp_rd    = beat;
  assign exp_addr  = idx;
  assign busy      = (state != S_IDLE);
  assign done      = done_r;
  // In the done cycle the last compare has not reached err_count yet.
  assign pass      = done_r ? clean : pass_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      skew_cnt <= '0;
      count    <= '0;
      idx      <= '0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (do_start) begin
              count    <= cfg_count;
              idx      <= '0;
              skew_cnt <= cfg_skew - 1'b1;
              if (cfg_count == '0)     state <= S_DRAIN;
              else if (cfg_skew != '0) state <= S_SKEW;
              else                     state <= S_RUN;
            end
          end
          S_SKEW: begin
            if (skew_cnt == '0) state <= S_RUN;
            else                skew_cnt <= skew_cnt - 1'b1;
          end
          S_RUN: begin
            if (dut_valid) begin
              idx <= idx + 1'b1;
              if (last_beat) state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            state  <= S_IDLE;
            done_r <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Align stage: hold the DUT beat until the SRAM returns its expected vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_valid <= 1'b0;
      beat_idx   <= '0;
      dut_align  <= '0;
      cmp_idx    <= '0;
    end else begin
      beat_valid <= beat;
      if (beat) begin
        beat_idx  <= idx;
        dut_align <= dut_data;
      end
      if (beat_valid) cmp_idx <= beat_idx;
    end
  end

  dct_lane_cmp #(
    .BW    (BW),
    .LANES (LANES)
  ) u_cmp (
    .clk       (clk),
    .reset     (reset),
    .flush     (abort),
    .in_valid  (beat_valid && !abort),
    .act_vec   (dut_align),
    .exp_vec   (exp_data),
    .out_valid (cmp_valid),
    .mask      (mask)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count       <= '0;
      lane_err        <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      pass_r          <= 1'b0;
    end else if (do_start) begin
      err_count       <= '0;
      lane_err        <= '0;
      first_err_valid <= 1'b0;
      first_err_addr  <= '0;
      pass_r          <= 1'b0;
    end else begin
      if (hit) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        lane_err <= lane_err | mask;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_addr  <= cmp_idx;
        end
      end
      if (done_r) pass_r <= clean;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dct_vec_checker.sv
`default_nettype none
// tb_dct_vec_checker -- table-driven and randomized checks against a run-level model.
// Rev 1.0
module tb_dct_vec_checker;

  localparam int BW    = 11;
  localparam int LANES = 8;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int SKW   = 16;
  localparam int CW    = AW + 1;
  localparam int VW    = LANES * BW;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start, abort, dut_valid;
  logic [SKW-1:0]    cfg_skew;
  logic [AW:0]       cfg_count;
  logic [VW-1:0]     dut_data, exp_data;
  logic [AW-1:0]     exp_addr, first_err_addr;
  logic              exp_rd, busy, done, pass, first_err_valid;
  logic [AW:0]       err_count;
  logic [LANES-1:0]  lane_err;

  logic [VW-1:0] mem     [DEPTH];
  logic [VW-1:0] dut_vec [DEPTH];

  int total = 0;
  int bad   = 0;

  dct_vec_checker #(
    .BW(BW), .LANES(LANES), .DEPTH(DEPTH), .AW(AW), .SKW(SKW)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .abort(abort),
    .cfg_skew(cfg_skew), .cfg_count(cfg_count),
    .dut_valid(dut_valid), .dut_data(dut_data),
    .exp_addr(exp_addr), .exp_rd(exp_rd), .exp_data(exp_data),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .lane_err(lane_err), .first_err_valid(first_err_valid),
    .first_err_addr(first_err_addr)
  );

  always #5 clk = ~clk;

  // Expected-vector SRAM: one-cycle registered read.
  always @(posedge clk) if (exp_rd) exp_data <= mem[exp_addr];

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  task automatic set_clean();
    for (int i = 0; i < DEPTH; i++) dut_vec[i] = mem[i];
  endtask

  task automatic flip(input int v, input int lane, input int b);
    logic [VW-1:0] one;
    one = '0;
    one[lane*BW + b] = 1'b1;
    dut_vec[v] = dut_vec[v] ^ one;
  endtask

  // Run-level reference: which of the first cnt vectors differ, and in which lanes.
  task automatic model(input int cnt, output int e, output logic [LANES-1:0] l, output int f);
    logic [LANES-1:0] m;
    e = 0; l = '0; f = -1;
    for (int i = 0; i < cnt; i++) begin
      m = '0;
      for (int ln = 0; ln < LANES; ln++)
        if (dut_vec[i][ln*BW +: BW] != mem[i][ln*BW +: BW]) m[ln] = 1'b1;
      if (m != '0) begin
        e++;
        l = l | m;
        if (f < 0) f = i;
      end
    end
  endtask

  // Entered at negedge+1; returns at negedge+1 of the cycle after done.
  task automatic do_run(input string tag, input int skew, input int cnt, input int mode,
                        input int e_err, input logic [LANES-1:0] e_lane,
                        input int e_first, input bit e_pass);
    int beats, first_k, last_k, done_k, addr_bad, f_exp;
    logic pass_at_done, busy1;
    cfg_skew  = SKW'(skew);
    cfg_count = CW'(cnt);
    start     = 1'b1;
    dut_valid = 1'b0;
    beats = 0; first_k = -1; last_k = -1; done_k = -1; addr_bad = 0;
    pass_at_done = 1'b0; busy1 = 1'b0;
    for (int k = 1; k < 20*DEPTH + skew + 40 && done_k < 0; k++) begin
      @(negedge clk);
      start = 1'b0;
      case (mode)
        0:       dut_valid = 1'b1;
        1:       dut_valid = (k % 2 == 0);
        default: dut_valid = 1'($urandom_range(0, 1));
      endcase
      dut_data = dut_vec[beats % DEPTH];
      #1;
      if (k == 1) busy1 = busy;
      if (exp_rd) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        if (int'(exp_addr) != beats) addr_bad++;
        beats++;
      end
      if (done) begin
        done_k = k;
        pass_at_done = pass;
      end
    end
    dut_valid = 1'b0;
    chk({tag, "_done_seen"}, done_k >= 0, 1);
    chk({tag, "_busy_rise"}, busy1, 1);
    chk({tag, "_reads"}, beats, cnt);
    if (cnt > 0) begin
      f_exp = skew + 1;
      if (mode == 1 && f_exp % 2 == 1) f_exp++;
      if (mode < 2) chk({tag, "_first_rd"}, first_k, f_exp);
      else          chk({tag, "_first_rd_late"}, first_k >= skew + 1, 1);
      chk({tag, "_done_lat"}, done_k, last_k + 2);
      chk({tag, "_addr_seq"}, addr_bad, 0);
    end else begin
      chk({tag, "_done_lat"}, done_k, 2);
    end
    chk({tag, "_pass_at_done"}, pass_at_done, e_pass);
    @(negedge clk);
    #1;
    chk({tag, "_idle"}, {busy, done}, 0);
    chk({tag, "_err_count"}, err_count, e_err);
    chk({tag, "_lane_err"}, lane_err, e_lane);
    chk({tag, "_first_valid"}, first_err_valid, e_first >= 0);
    chk({tag, "_first_addr"}, first_err_addr, (e_first >= 0) ? e_first : 0);
    chk({tag, "_pass_level"}, pass, e_pass);
  endtask

  typedef struct {
    int               skew;
    int               cnt;
    int               mode;
    int               corrupt;
    int               e_err;
    logic [LANES-1:0] e_lane;
    int               e_first;
    bit               e_pass;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int               e, f, aborted_k, guard;
    logic [LANES-1:0] l;
    bit               flag;

    tbl[0] = '{0, 16, 0, 0, 0, 8'h00, -1, 1'b1};
    tbl[1] = '{0, 16, 0, 1, 2, 8'h89,  5, 1'b0};
    tbl[2] = '{9, 16, 1, 0, 0, 8'h00, -1, 1'b1};
    tbl[3] = '{0,  0, 0, 0, 0, 8'h00, -1, 1'b1};
    tbl[4] = '{5, 64, 0, 2, 1, 8'h40, 63, 1'b0};
    tbl[5] = '{0,  1, 1, 3, 1, 8'h01,  0, 1'b0};

    for (int i = 0; i < DEPTH; i++) mem[i] = VW'({$urandom(), $urandom(), $urandom()});

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; dut_valid = 1'b0;
    cfg_skew = '0; cfg_count = '0; dut_data = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_state", {exp_addr, exp_rd, busy, done, pass, err_count, lane_err,
                        first_err_valid, first_err_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    for (int t = 0; t < 6; t++) begin
      set_clean();
      case (tbl[t].corrupt)
        1: begin flip(5, 3, 4); flip(9, 0, 0); flip(9, 7, 10); end
        2: flip(63, 6, 2);
        3: flip(0, 0, 7);
        default: ;
      endcase
      do_run($sformatf("tbl%0d", t), tbl[t].skew, tbl[t].cnt, tbl[t].mode,
             tbl[t].e_err, tbl[t].e_lane, tbl[t].e_first, tbl[t].e_pass);
    end

    for (int r = 0; r < 6; r++) begin
      int sk, cn;
      set_clean();
      for (int i = 0; i < DEPTH; i++)
        if ($urandom_range(0, 7) == 0) flip(i, $urandom_range(0, LANES-1), $urandom_range(0, BW-1));
      sk = $urandom_range(0, 20);
      cn = $urandom_range(1, DEPTH);
      model(cn, e, l, f);
      do_run($sformatf("rnd%0d", r), sk, cn, 2, e, l, f, e == 0);
    end

    // Abort at beat 7 with an error already counted in vector 2.
    set_clean();
    flip(2, 1, 3);
    cfg_skew = '0; cfg_count = CW'(16); start = 1'b1;
    e = 0; guard = 0;
    while (e < 7 && guard < 40) begin
      @(negedge clk);
      start = 1'b0; dut_valid = 1'b1; dut_data = dut_vec[e];
      #1;
      if (exp_rd) e++;
      guard++;
    end
    chk("abort_reach_beat7", e, 7);
    @(negedge clk);
    abort = 1'b1; dut_valid = 1'b1; dut_data = dut_vec[7];
    @(negedge clk);
    abort = 1'b0;
    #1;
    chk("abort_busy_low", busy, 0);
    chk("abort_err_hold", err_count, 1);
    flag = 1'b0;
    aborted_k = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (done || exp_rd) flag = 1'b1;
      aborted_k++;
    end
    chk("abort_no_done", flag, 0);
    dut_valid = 1'b0;
    set_clean();
    do_run("after_abort", 0, 16, 0, 0, '0, -1, 1'b1);

    // Reset at beat 4 with an error already counted in vector 1.
    flip(1, 5, 1);
    cfg_skew = '0; cfg_count = CW'(16); start = 1'b1;
    e = 0; guard = 0;
    while (e < 4 && guard < 40) begin
      @(negedge clk);
      start = 1'b0; dut_valid = 1'b1; dut_data = dut_vec[e];
      #1;
      if (exp_rd) e++;
      guard++;
    end
    @(negedge clk);
    dut_data = dut_vec[e];
    #1;
    chk("pre_reset_err", err_count, 1);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", {exp_addr, exp_rd, busy, done, pass, err_count, lane_err,
                                 first_err_valid, first_err_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dut_valid = 1'b0;
    flag = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (done || busy) flag = 1'b1;
    end
    chk("post_reset_idle", flag, 0);
    set_clean();
    do_run("after_reset", 2, 16, 0, 0, '0, -1, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
